// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle between a requester and the serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Co;

    modport master (
        output start, A, B, Ci,
        input  busy, done, S, Co
    );

    modport slave (
        input  start, A, B, Ci,
        output busy, done, S, Co
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell with a registered carry
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave sa
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-2:0] r_psum;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    logic             w_sum_bit;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_psum_cat;

    assign w_sum_bit  = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; on the last bit this concatenation is the full sum.
    assign w_psum_cat = {w_sum_bit, r_psum};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (sa.start) w_next_state = RUN;
            RUN:     if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_psum  <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sa.start) begin
                        r_a     <= sa.A;
                        r_b     <= sa.B;
                        r_c     <= sa.Ci;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_c     <= w_carry;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_psum  <= w_psum_cat[WIDTH-1:1];
                    if (w_last) begin
                        r_s  <= w_psum_cat;
                        r_co <= w_carry;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sa.busy = (r_state == RUN);
    assign sa.done = (r_state == DONE);
    assign sa.S    = r_s;
    assign sa.Co   = r_co;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .sa  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full operation with start pulsed for one cycle; result from plain addition.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                          input string tag);
        logic [WIDTH:0] expv;
        int             busy_cycles;
        expv = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        bus.A = a; bus.B = b; bus.Ci = ci; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cycles++;
            tick();
        end
        check({tag, "_busy_cycles"}, busy_cycles, WIDTH);
        check({tag, "_done"}, {bus.busy, bus.done}, 2'b01);
        check({tag, "_sum"}, {bus.Co, bus.S}, expv);
        tick();
        check({tag, "_idle"}, {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        int               pulses, last_pulse, bad_gap, stray;

        bus.start = 1'b1; bus.A = '0; bus.B = '0; bus.Ci = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_state", {bus.busy, bus.done, bus.Co, bus.S}, '0);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        tick();

        bus.A = 8'h5A; bus.B = 8'h01; bus.start = 1'b1;
        tick();
        check("first_accept", bus.busy, 1'b1);
        bus.start = 1'b0;
        repeat (WIDTH + 1) tick();
        check("first_result", {bus.Co, bus.S}, 9'h05B);

        run_op(8'hFF, 8'h01, 1'b0, "ff_01");
        repeat (5) tick();
        check("hold_after_5", {bus.Co, bus.S}, 9'h100);

        run_op(8'hFF, 8'hFF, 1'b1, "ff_ff_c");
        run_op(8'h3C, 8'h0F, 1'b1, "3c_0f_c");
        check("3c_0f_value", {bus.Co, bus.S}, 9'h04C);

        // Inputs change after the accept and start pulses mid-run.
        bus.A = 8'h01; bus.B = 8'h02; bus.Ci = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A = 8'hAA; bus.B = 8'h55; bus.Ci = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            bus.start = (i == 3);
            tick();
        end
        bus.start = 1'b0;
        check("iso_done_timing", bus.done, 1'b1);
        check("iso_sum", {bus.Co, bus.S}, 9'h003);
        tick();
        tick();
        check("iso_no_extra_op", {bus.busy, bus.done}, 2'b00);

        // Held start: one op per IDLE visit, period WIDTH+2.
        bus.A = 8'h10; bus.B = 8'h20; bus.Ci = 1'b0; bus.start = 1'b1;
        pulses = 0; last_pulse = -1; bad_gap = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                check("held_sum", {bus.Co, bus.S}, 9'h030);
                if (last_pulse >= 0 && (c - last_pulse) != WIDTH + 2) bad_gap++;
                last_pulse = c;
                pulses++;
            end
        end
        bus.start = 1'b0;
        check("held_pulses", pulses, 3);
        check("held_period", bad_gap, 0);
        repeat (WIDTH + 2) tick();

        // Reset on the 4th RUN cycle aborts the operation.
        bus.A = 8'h80; bus.B = 8'h80; bus.Ci = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {bus.busy, bus.done, bus.Co, bus.S}, '0);
        stray = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        check("abort_no_done", stray, 0);
        run_op(8'h80, 8'h80, 1'b0, "80_80");

        for (int n = 0; n < 20; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
